// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: status codes, dumper state encodings and dump header bytes.
package iagc_pkg;

  typedef enum logic [2:0] {
    IAGC_STATUS_IDLE,
    IAGC_STATUS_SAMPLE,
    IAGC_STATUS_DUMP_REF,
    IAGC_STATUS_DUMP_ERR
  } iagc_status_e;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StRead,
    StWaitRd,
    StSend,
    StNext,
    StEnd
  } dump_state_e;

  localparam logic [7:0] DUMP_SYNC   = 8'hA5;
  localparam logic [7:0] DUMP_ID_REF = 8'h01;
  localparam logic [7:0] DUMP_ID_ERR = 8'h02;

endpackage

// File: rtl/word_serializer.sv
// Loads a WIDTH-bit word and emits it MSB byte first over a valid/ready byte interface.
module word_serializer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_done
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned CW     = $clog2(NBYTES + 1);

  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    idx_q;
  logic             valid_q;
  logic             xfer;
  logic             last;

  assign xfer = valid_q && i_ready;
  assign last = (idx_q == CW'(NBYTES - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      shift_q <= i_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      if (last) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= shift_q << 8;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

  assign o_data  = shift_q[WIDTH-1 -: 8];
  assign o_valid = valid_q;
  assign o_done  = xfer && last;

endmodule

// File: rtl/sample_dumper.sv
// Dumps the reference or error sample memory as a byte stream to the UART transmitter.
// Optional SAMPLE_DUMPER_HEADER_EN prefixes every dump with a sync byte and channel ID.
module sample_dumper
  import iagc_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned ADDR_SIZE  = 12,
  parameter int unsigned END_CYCLES = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_select,
  input  logic [ADDR_SIZE-1:0] i_memory_size,
  output logic [ADDR_SIZE-1:0] o_addr,
  input  logic [DATA_SIZE-1:0] i_ref_data,
  input  logic [DATA_SIZE-1:0] i_err_data,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic                 o_busy,
  output logic                 o_end
);

  localparam int unsigned EW = $clog2(END_CYCLES + 1);

  dump_state_e          state_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] size_q;
  logic                 select_q;
  logic                 busy_q;
  logic                 end_q;
  logic [EW-1:0]        end_cnt_q;

  logic                 word_load;
  logic                 word_done;
  logic [7:0]           word_data;
  logic                 word_valid;

  assign word_load = (state_q == StWaitRd);

  word_serializer #(
    .WIDTH (DATA_SIZE)
  ) u_word_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (word_load),
    .i_word  (select_q ? i_err_data : i_ref_data),
    .o_data  (word_data),
    .o_valid (word_valid),
    .i_ready (i_tx_ready),
    .o_done  (word_done)
  );

`ifdef SAMPLE_DUMPER_HEADER_EN
  logic       hdr_load;
  logic       hdr_done;
  logic [7:0] hdr_data;
  logic       hdr_valid;

  assign hdr_load = (state_q == StIdle) && i_start;

  word_serializer #(
    .WIDTH (16)
  ) u_hdr_serializer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (hdr_load),
    .i_word  ({DUMP_SYNC, (i_select ? DUMP_ID_ERR : DUMP_ID_REF)}),
    .o_data  (hdr_data),
    .o_valid (hdr_valid),
    .i_ready (i_tx_ready),
    .o_done  (hdr_done)
  );

  // Header and data phases never overlap, so a plain mux is glitch-free here.
  assign o_tx_data  = hdr_valid ? hdr_data : word_data;
  assign o_tx_valid = hdr_valid | word_valid;
`else
  assign o_tx_data  = word_data;
  assign o_tx_valid = word_valid;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      select_q  <= 1'b0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      end_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            select_q <= i_select;
            size_q   <= i_memory_size;
            addr_q   <= '0;
            busy_q   <= 1'b1;
`ifdef SAMPLE_DUMPER_HEADER_EN
            state_q  <= StHdr;
`else
            if (i_memory_size == '0) begin
              state_q   <= StEnd;
              end_q     <= 1'b1;
              end_cnt_q <= '0;
            end else begin
              state_q <= StRead;
            end
`endif
          end
        end
`ifdef SAMPLE_DUMPER_HEADER_EN
        StHdr: begin
          if (hdr_done) begin
            if (size_q == '0) begin
              state_q   <= StEnd;
              end_q     <= 1'b1;
              end_cnt_q <= '0;
            end else begin
              state_q <= StRead;
            end
          end
        end
`endif
        StRead:   state_q <= StWaitRd;
        StWaitRd: state_q <= StSend;
        StSend: begin
          if (word_done) state_q <= StNext;
        end
        StNext: begin
          if (addr_q == size_q - 1'b1) begin
            state_q   <= StEnd;
            addr_q    <= '0;
            end_q     <= 1'b1;
            end_cnt_q <= '0;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= StRead;
          end
        end
        StEnd: begin
          if (end_cnt_q == EW'(END_CYCLES - 1)) begin
            end_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            end_cnt_q <= end_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_addr = addr_q;
  assign o_busy = busy_q;
  assign o_end  = end_q;

endmodule

// File: tb/tb_sample_dumper.sv
// Scoreboard bench for sample_dumper: expected bytes queued at start, popped on each handshake.
module tb_sample_dumper;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] size = '0;
  logic [AW-1:0] addr;
  logic [15:0]   ref_rd, err_rd;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy, dend;

  logic [15:0] ref_mem [0:15];
  logic [15:0] err_mem [0:15];

  typedef struct packed {
    logic [7:0]    data;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int bytes_seen = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ref_rd <= ref_mem[addr[3:0]];
    err_rd <= err_mem[addr[3:0]];
  end

  sample_dumper u_dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_select      (sel),
    .i_memory_size (size),
    .o_addr        (addr),
    .i_ref_data    (ref_rd),
    .i_err_data    (err_rd),
    .o_tx_data     (tx_data),
    .o_tx_valid    (tx_valid),
    .i_tx_ready    (tx_ready),
    .o_busy        (busy),
    .o_end         (dend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change #1 after posedge, so a handshake seen here is the one the next edge takes.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      exp_t e;
      bytes_seen++;
      if (exp_q.size() == 0) begin
        chk("extra_byte", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("byte", {24'h0, tx_data}, {24'h0, e.data});
        chk("byte_addr", {20'h0, addr}, {20'h0, e.addr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic s, input int n);
    exp_t e;
    logic [15:0] w;
`ifdef SAMPLE_DUMPER_HEADER_EN
    e.addr = '0;
    e.data = 8'hA5;
    exp_q.push_back(e);
    e.data = s ? 8'h02 : 8'h01;
    exp_q.push_back(e);
`endif
    for (int a = 0; a < n; a++) begin
      w = s ? err_mem[a] : ref_mem[a];
      e.addr = AW'(a);
      e.data = w[15:8];
      exp_q.push_back(e);
      e.data = w[7:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic kick(input logic s, input int n);
    push_expect(s, n);
    sel   = s;
    size  = AW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on_start", {31'h0, busy}, 32'h1);
  endtask

  // Waits for o_end, optionally firing stray starts / toggling select, then checks the end pulse.
  task automatic wait_end(input string tag, input bit spur, input bit tog);
    int n = 0;
    int cnt = 0;
    while (!dend && n < 500) begin
      start = spur && (n == 4 || n == 10);
      if (tog) sel = ~sel;
      tick();
      n++;
    end
    start = 1'b0;
    chk({tag, "_end_seen"}, {31'h0, dend}, 32'h1);
    while (dend && cnt < 20) begin
      cnt++;
      start = spur && (cnt == 4);
      tick();
    end
    start = 1'b0;
    chk({tag, "_end_len"}, cnt, 4);
    chk({tag, "_busy_off"}, {31'h0, busy}, 32'h0);
    chk({tag, "_addr_home"}, {20'h0, addr}, 32'h0);
    chk({tag, "_all_bytes"}, exp_q.size(), 0);
    tick();
    chk({tag, "_idle_after"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int lat;
    int n;
    int b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 16'h1111 * 16'(i + 1);
      err_mem[i] = 16'hE000 + 16'(i);
    end
    ref_mem[0] = 16'h1234;
    ref_mem[1] = 16'hABCD;
    ref_mem[2] = 16'h00FF;
    err_mem[0] = 16'hBEEF;
    err_mem[1] = 16'hC0DE;

    repeat (3) tick();
    chk("rst_addr", {20'h0, addr}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_end", {31'h0, dend}, 32'h0);
    rst = 1'b0;
    tick();

    // Ref dump with latency measurement and backpressure on 0x34.
    kick(1'b0, 3);
    lat = 1;
    while (!tx_valid && lat < 20) begin
      tick();
      lat++;
    end
`ifdef SAMPLE_DUMPER_HEADER_EN
    chk("latency", lat, 1);
`else
    chk("latency", lat, 3);
`endif
    n = 0;
    while (!(tx_valid && tx_data == 8'h34) && n < 50) begin
      tick();
      n++;
    end
    chk("bp_reach", {24'h0, tx_data}, 32'h34);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", {24'h0, tx_data}, 32'h34);
      chk("bp_valid", {31'h0, tx_valid}, 32'h1);
    end
    tx_ready = 1'b1;
    wait_end("ref3", 1'b0, 1'b0);

    // Same dump with stray starts during busy and on the END exit cycle.
    kick(1'b0, 3);
    wait_end("ref3_spur", 1'b1, 1'b0);

    // Err dump with select toggling mid-dump.
    kick(1'b1, 2);
    wait_end("err2", 1'b0, 1'b1);

    // Empty dump.
    kick(1'b0, 0);
    wait_end("empty", 1'b0, 1'b0);

    // Reset after the third byte, then a fresh dump from address 0.
    b0 = bytes_seen;
    kick(1'b0, 3);
    n = 0;
    while (bytes_seen < b0 + 3 && n < 100) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_addr", {20'h0, addr}, 32'h0);
    chk("mid_rst_end", {31'h0, dend}, 32'h0);
    exp_q.delete();
    rst = 1'b0;
    b0 = bytes_seen;
    repeat (10) tick();
    chk("no_bytes_after_rst", bytes_seen, b0);
    kick(1'b0, 2);
    wait_end("after_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
